// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory request/response, redirect
// from branch resolution, and the write side of the IF/ID register.
interface instruction_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGrant;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        ifidEnable;
  logic        fetchValid_IF;
  logic [31:0] pcAddress_IF;
  logic [31:0] instructionCode_IF;
  logic [31:0] pcPlusFour_IF;

  // fetch unit side
  modport master (
    output imemReq, imemAddr,
    input  imemGrant, imemRespValid, imemRespData,
    input  redirectValid, redirectTarget, ifidEnable,
    output fetchValid_IF, pcAddress_IF, instructionCode_IF, pcPlusFour_IF
  );

  // memory / pipeline side
  modport slave (
    input  imemReq, imemAddr,
    output imemGrant, imemRespValid, imemRespData,
    output redirectValid, redirectTarget, ifidEnable,
    input  fetchValid_IF, pcAddress_IF, instructionCode_IF, pcPlusFour_IF
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests,
// buffers returned words in a small FIFO and presents the FIFO head to IF/ID.
// A request is only issued when outstanding + buffered < DEPTH, so every
// granted fetch is guaranteed a FIFO slot when it returns. A redirect empties
// the FIFO and marks every in-flight response for discard.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_CODE = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discardCount;
  logic [CW-1:0] count;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [31:0]   pcMem    [DEPTH];
  logic [31:0]   instrMem [DEPTH];

  logic [31:0]   targetAligned;
  logic [CW-1:0] respDec;
  logic          haveCredit;
  logic          grant;
  logic          push;
  logic          pop;
  logic          headValid;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign targetAligned = bus.redirectTarget & 32'hFFFF_FFFC;
  assign respDec       = CW'(bus.imemRespValid);
  assign haveCredit    = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(DEPTH);
  assign bus.imemReq   = !bus.redirectValid && haveCredit;
  assign bus.imemAddr  = fetchPc;
  assign grant         = bus.imemReq && bus.imemGrant;
  assign push          = bus.imemRespValid && (discardCount == '0) && !bus.redirectValid;
  assign headValid     = (count != '0);
  assign pop           = bus.ifidEnable && headValid && !bus.redirectValid;

  // PC, credit, discard and FIFO pointer bookkeeping; redirect overrides all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc      <= RESET_PC;
      respPc       <= RESET_PC;
      outstanding  <= '0;
      discardCount <= '0;
      count        <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
    end else if (bus.redirectValid) begin
      fetchPc      <= targetAligned;
      respPc       <= targetAligned;
      count        <= '0;
      rdPtr        <= '0;
      wrPtr        <= '0;
      // a response landing in the redirect cycle is already accounted for
      outstanding  <= outstanding - respDec;
      discardCount <= outstanding - respDec;
    end else begin
      if (grant) begin
        fetchPc <= fetchPc + 32'd4;
      end
      case ({grant, bus.imemRespValid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: ;
      endcase
      if (bus.imemRespValid && (discardCount != '0)) begin
        discardCount <= discardCount - CW'(1);
      end
      if (push) begin
        respPc <= respPc + 32'd4;
        wrPtr  <= next_ptr(wrPtr);
      end
      if (pop) begin
        rdPtr <= next_ptr(rdPtr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO payload storage; contents are only observed while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr]    <= respPc;
      instrMem[wrPtr] <= bus.imemRespData;
    end
  end

  assign bus.fetchValid_IF      = headValid;
  assign bus.pcAddress_IF       = headValid ? pcMem[rdPtr] : 32'h0000_0000;
  assign bus.instructionCode_IF = headValid ? instrMem[rdPtr] : NOP_CODE;
  assign bus.pcPlusFour_IF      = bus.pcAddress_IF + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit. The reference model says:
// since the last reset/redirect to T, the delivered instruction stream is
// T, T+4, T+8, ... each carrying the memory word at that address, and the
// granted request addresses follow the same sequence.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_CODE(NOP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] code; } exp_t;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int popCount = 0;
  req_t memQ[$];
  exp_t expQ[$];
  logic [31:0] expNextPc;
  logic [31:0] expFetchPc;
  int latMin = 1, latMax = 1;
  int grantPct = 100, enPct = 100, redirPct = 0;
  bit holdPending = 0;
  logic [31:0] holdAddr;
  exp_t e;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic top_up();
    while (expQ.size() < 4) begin
      expQ.push_back('{pc: expNextPc, code: word_at(expNextPc)});
      expNextPc = expNextPc + 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    expQ.delete();
    expNextPc  = pc;
    expFetchPc = pc;
    holdPending = 0;
    top_up();
  endtask

  task automatic idle_inputs();
    bus.redirectValid  = 1'b0;
    bus.redirectTarget = 32'h0;
    bus.imemGrant      = 1'b0;
    bus.imemRespValid  = 1'b0;
    bus.imemRespData   = 32'h0;
    bus.ifidEnable     = 1'b0;
  endtask

  // one cycle of stimulus plus the memory model; inputs change at negedge
  task automatic step(input bit redir = 1'b0, input logic [31:0] tgt = 32'h0);
    logic [31:0] t;
    int lat;
    @(negedge clk);
    cyc++;
    bus.redirectValid  = redir || ($urandom_range(99) < redirPct);
    t = redir ? tgt : $urandom;
    bus.redirectTarget = t;
    bus.imemGrant      = ($urandom_range(99) < grantPct);
    bus.ifidEnable     = ($urandom_range(99) < enPct);
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      bus.imemRespValid = 1'b1;
      bus.imemRespData  = word_at(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      bus.imemRespValid = 1'b0;
      bus.imemRespData  = $urandom;
    end
    #1;
    if (bus.redirectValid) begin
      chk("req_during_redirect", {31'b0, bus.imemReq}, 32'd0);
      restart_model(t & 32'hFFFF_FFFC);
    end else begin
      if (holdPending) begin
        chk("held_req", {31'b0, bus.imemReq}, 32'd1);
        chk("held_addr", bus.imemAddr, holdAddr);
      end
      if (bus.imemReq && bus.imemGrant) begin
        chk("grant_addr", bus.imemAddr, expFetchPc);
        lat = $urandom_range(latMax, latMin);
        memQ.push_back('{addr: bus.imemAddr, due: cyc + lat});
        expFetchPc = expFetchPc + 32'd4;
        chk("credit_limit", {31'b0, memQ.size() <= DEPTH}, 32'd1);
      end
      holdPending = bus.imemReq && !bus.imemGrant;
      holdAddr    = bus.imemAddr;
    end
    top_up();
  endtask

  // asynchronous reset mid-cycle; memory forgets its in-flight requests too
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #3;
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.fetchValid_IF}, 32'd0);
    chk("rst_pc", bus.pcAddress_IF, 32'h0);
    chk("rst_code", bus.instructionCode_IF, NOP);
    chk("rst_p4", bus.pcPlusFour_IF, 32'h4);
    memQ.delete();
    restart_model(RESET_PC);
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b1;
  endtask

  // monitor: compares every output and every pop against the scoreboard
  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (bus.fetchValid_IF) begin
        chk("pc_plus_four", bus.pcPlusFour_IF, bus.pcAddress_IF + 32'd4);
        if (bus.ifidEnable && !bus.redirectValid) begin
          if (expQ.size() == 0) begin
            chk("scoreboard_empty", bus.pcAddress_IF, 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            chk("pop_pc", bus.pcAddress_IF, e.pc);
            chk("pop_code", bus.instructionCode_IF, e.code);
            popCount++;
          end
        end
      end else begin
        chk("idle_pc", bus.pcAddress_IF, 32'h0);
        chk("idle_code", bus.instructionCode_IF, NOP);
        chk("idle_p4", bus.pcPlusFour_IF, 32'h4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int startPop;
    int i;
    idle_inputs();
    restart_model(RESET_PC);

    // reset release, streaming fetch
    do_reset();
    grantPct = 100; enPct = 100; latMin = 1; latMax = 1;
    step();
    chk("t1_req", {31'b0, bus.imemReq}, 32'd1);
    chk("t1_addr0", bus.imemAddr, 32'h0);
    step();
    chk("t1_valid_c1", {31'b0, bus.fetchValid_IF}, 32'd0);
    step();
    chk("t1_valid_c2", {31'b0, bus.fetchValid_IF}, 32'd1);
    chk("t1_pc_c2", bus.pcAddress_IF, 32'h0);
    chk("t1_code_c2", bus.instructionCode_IF, word_at(32'h0));
    chk("t1_p4_c2", bus.pcPlusFour_IF, 32'h4);
    step();
    chk("t1_pc_c3", bus.pcAddress_IF, 32'h4);
    repeat (6) step();

    // IF/ID stall fills the FIFO and blocks requests
    do_reset();
    enPct = 0;
    repeat (5) step();
    chk("t2_req_full", {31'b0, bus.imemReq}, 32'd0);
    chk("t2_head_valid", {31'b0, bus.fetchValid_IF}, 32'd1);
    chk("t2_head_pc", bus.pcAddress_IF, 32'h0);
    enPct = 100;
    step();
    chk("t2_pop0", bus.pcAddress_IF, 32'h0);
    step();
    chk("t2_pop4", bus.pcAddress_IF, 32'h4);
    chk("t2_resume_req", {31'b0, bus.imemReq}, 32'd1);
    chk("t2_resume_addr", bus.imemAddr, 32'h8);
    repeat (6) step();

    // redirect with two fetches in flight
    do_reset();
    latMin = 4; latMax = 4;
    step();
    step();
    step(1'b1, 32'h0000_0103);
    step();
    chk("t3_next_addr", bus.imemAddr, 32'h100);
    i = 0;
    while (!bus.fetchValid_IF && i < 15) begin
      step();
      i++;
    end
    chk("t3_valid", {31'b0, bus.fetchValid_IF}, 32'd1);
    chk("t3_first_pc", bus.pcAddress_IF, 32'h100);
    repeat (5) step();

    // grant withheld while fetching 0x10
    do_reset();
    latMin = 1; latMax = 1;
    i = 0;
    while (expFetchPc != 32'h10 && i < 20) begin
      step();
      i++;
    end
    chk("t4_reached", expFetchPc, 32'h10);
    grantPct = 0;
    repeat (3) begin
      step();
      chk("t4_stable_addr", bus.imemAddr, 32'h10);
    end
    grantPct = 100;
    repeat (10) step();

    // redirect to the top of the address space, wrap to 0
    step(1'b1, 32'hFFFF_FFFC);
    step();
    chk("t5_req", {31'b0, bus.imemReq}, 32'd1);
    chk("t5_addr", bus.imemAddr, 32'hFFFF_FFFC);
    step();
    chk("t5_valid_r2", {31'b0, bus.fetchValid_IF}, 32'd0);
    chk("t5_wrap_addr", bus.imemAddr, 32'h0);
    step();
    chk("t5_valid_r3", {31'b0, bus.fetchValid_IF}, 32'd1);
    chk("t5_pc", bus.pcAddress_IF, 32'hFFFF_FFFC);
    chk("t5_p4", bus.pcPlusFour_IF, 32'h0);
    repeat (5) step();

    // reset with buffered and in-flight fetches
    enPct = 0; latMin = 3; latMax = 3;
    repeat (4) step();
    chk("t6_pre_valid", {31'b0, bus.fetchValid_IF}, 32'd1);
    do_reset();
    enPct = 100; latMin = 1; latMax = 1;
    step();
    chk("t6_restart_addr", bus.imemAddr, RESET_PC);
    repeat (12) step();

    // randomized traffic with redirects
    latMin = 1; latMax = 4; grantPct = 70; enPct = 70; redirPct = 3;
    startPop = popCount;
    repeat (3000) step();
    chk("rand_liveness", {31'b0, (popCount - startPop) > 200}, 32'd1);
    redirPct = 0; grantPct = 100; enPct = 100; latMin = 1; latMax = 1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
